uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx transmitter between N byte-stream requesters (replayer, reply_cnt, sample reader, …). It replaces ad-hoc TX muxing in the top level.
- Grants are round-robin and packet-locked: once a requester owns the transmitter, it keeps it until it sends a byte flagged last, or until a watchdog revokes the grant.
- Drives uart_tx start/data and paces bytes from uart_tx active/done.

Parameters:
- N, 3, number of requesters (2..8).
- TIMEOUT, 1024, cycles the owner may leave req_valid low between bytes before its grant is revoked.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high.
- req_valid  in  N  requester i has a byte on req_data[8i+7:8i].
- req_data  in  8N  packed byte per requester.
- req_last  in  N  byte on requester i ends its packet.
- req_ready  out  N  one-cycle pulse: requester i's byte was accepted this cycle.
- grant  out  N  one-hot current owner, or all zero.
- tx_start  out  1  one-cycle start pulse to uart_tx.
- tx_data  out  8  byte to uart_tx; held stable from the start pulse until done.
- tx_active  in  1  uart_tx busy.
- tx_done  in  1  uart_tx one-cycle end-of-byte pulse.
- busy  out  1  high when state is not IDLE.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by the watchdog.

Behaviour:
- All outputs are registered.
- Reset (synchronous, any state, including mid-byte):
  - state = IDLE; grant, req_ready, tx_start, busy, timeout_err = 0; tx_data = 0.
  - last_owner = N-1, so requester 0 has first priority; idle counter = 0.
  - An in-flight uart_tx byte completes on the line, but its tx_done is ignored.
- States: IDLE, LOAD, WAIT_DONE.
- IDLE:
  - If any req_valid is high, pick the first requester with req_valid high, searching from last_owner+1 upward modulo N.
  - Set grant to that one-hot, clear the idle counter, go to LOAD.
  - If no req_valid is high, stay in IDLE.
- LOAD, with owner valid and tx_active low:
  - tx_data <= owner's byte; tx_start = 1 for exactly one cycle; req_ready[owner] = 1 for the same cycle.
  - last_flag <= req_last[owner]; go to WAIT_DONE.
- LOAD, with owner valid but tx_active high (leftover byte after a reset): stall; the idle counter does not advance.
- LOAD, with owner req_valid low:
  - Idle counter increments.
  - When it reaches TIMEOUT-1: clear grant, pulse timeout_err, last_owner <= owner, go to IDLE.
- WAIT_DONE:
  - Ignore tx_done in the same cycle as tx_start.
  - On a later tx_done with last_flag = 1: clear grant, last_owner <= owner, go to IDLE.
  - On a later tx_done with last_flag = 0: clear the idle counter, go to LOAD.
- Req_valid of non-owners is ignored while a grant is held; no preemption.
- Latency:
  - req_valid rising in IDLE gives grant on the next edge and tx_start/req_ready on the edge after that (2 cycles).
  - Within a packet, tx_done gives the next tx_start 2 cycles later.
- Simultaneous requests: resolved by the round-robin order only.
- Wrap: the search pointer wraps from N-1 to 0.
- Fairness: the release cycle and a new grant cannot overlap. At least one IDLE cycle separates packets.
- Requester contract: req_data and req_last must be stable while req_valid is high until req_ready; they are sampled only in the req_ready cycle.
- busy = (state != IDLE).

Test Plan:
- N=3, reset, then req_valid=3'b001 with a 2-byte packet 0x41, 0x42 (last on 0x42):
  - grant=001 one cycle after valid; tx_start with tx_data=0x41 the cycle after that.
  - Second start 2 cycles after tx_done; grant clears after the second tx_done.
- req_valid=3'b111 from IDLE, each requester sending a single last byte 0xA0/0xA1/0xA2:
  - Bytes go out in order 0, 1, 2, then 0 again if it re-requests.
  - Exactly one grant bit is high at any time.
- Requester 1 is mid-packet (sent 0x10, not last) when requester 2 raises valid:
  - Requester 1's next byte 0x11 (last) is sent before any requester 2 byte.
- TIMEOUT=16: owner 0 sends a non-last byte, then holds req_valid low:
  - timeout_err pulses 16 cycles after entering LOAD; grant=000.
  - A pending requester 1 is granted next.
- Reset is asserted during WAIT_DONE:
  - The next cycle shows all outputs zero and state IDLE.
  - A stale tx_done is ignored.
  - A new request waits in LOAD until tx_active is low, then gets tx_start.
- tx_done pulse in the same cycle as tx_start (bench stub):
  - No state change; only a later tx_done advances the block.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one uart_tx between N byte-stream
// requesters. A watchdog revokes the grant when the owner stalls between bytes.
module uart_tx_arbiter #(
  parameter int N       = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   grant,
  output logic           tx_start,
  output logic [7:0]     tx_data,
  input  logic           tx_active,
  input  logic           tx_done,
  output logic           busy,
  output logic           timeout_err
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [OW-1:0] LAST_IDX = OW'(N - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  req_ready_q, req_ready_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_owner_q, last_owner_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic          last_flag_q, last_flag_d;
  logic          tx_start_q, tx_start_d;
  logic          timeout_err_q, timeout_err_d;
  logic          busy_q, busy_d;
  logic [7:0]    tx_data_q, tx_data_d;

  logic          own_valid, own_last;
  logic [7:0]    own_data;
  logic          pick_found;
  logic [OW-1:0] pick_idx;

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == OW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[8*i +: 8];
      end
    end
  end

  // Search starts just after the previous owner and wraps past N-1 back to 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!pick_found && req_valid[i] &&
            ((int'(last_owner_q) + k == i) || (int'(last_owner_q) + k == i + N))) begin
          pick_found = 1'b1;
          pick_idx   = OW'(i);
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    idle_cnt_d    = idle_cnt_q;
    last_flag_d   = last_flag_q;
    tx_data_d     = tx_data_q;
    req_ready_d   = '0;
    tx_start_d    = 1'b0;
    timeout_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d    = pick_idx;
          idle_cnt_d = '0;
          state_d    = LOAD;
          for (int i = 0; i < N; i++) grant_d[i] = (pick_idx == OW'(i));
        end
      end
      LOAD: begin
        // A leftover byte after reset keeps tx_active high; stall without aging.
        if (own_valid) begin
          if (!tx_active) begin
            tx_data_d   = own_data;
            tx_start_d  = 1'b1;
            req_ready_d = grant_q;
            last_flag_d = own_last;
            state_d     = WAIT_DONE;
          end
        end else if (idle_cnt_q == CNT_MAX) begin
          grant_d       = '0;
          timeout_err_d = 1'b1;
          last_owner_d  = owner_q;
          state_d       = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        // A done coinciding with our own start pulse belongs to an earlier byte.
        if (tx_done && !tx_start_q) begin
          if (last_flag_q) begin
            grant_d      = '0;
            last_owner_d = owner_q;
            state_d      = IDLE;
          end else begin
            idle_cnt_d = '0;
            state_d    = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      req_ready_q   <= '0;
      owner_q       <= '0;
      last_owner_q  <= LAST_IDX;
      idle_cnt_q    <= '0;
      last_flag_q   <= 1'b0;
      tx_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
      tx_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      req_ready_q   <= req_ready_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      idle_cnt_q    <= idle_cnt_d;
      last_flag_q   <= last_flag_d;
      tx_start_q    <= tx_start_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
      tx_data_q     <= tx_data_d;
    end
  end

  assign grant       = grant_q;
  assign req_ready   = req_ready_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: uart_tx stub, queue-based requesters and a
// packet-level scoreboard, plus directed round-robin table and corner sequences.
module tb_uart_tx_arbiter;
  localparam int N  = 3;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic           tx_start, tx_active, tx_done, busy, timeout_err;
  logic [7:0]     tx_data;

  uart_tx_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant),
    .tx_start(tx_start), .tx_data(tx_data), .tx_active(tx_active),
    .tx_done(tx_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // uart_tx stub: busy for byte_cyc cycles after a start, then a done pulse
  logic stub_en = 1'b1, stub_active = 1'b0, stub_done = 1'b0;
  logic man_active = 1'b0, man_done = 1'b0;
  int   stub_cnt = 0;
  int   byte_cyc = 4;
  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        stub_active <= 1'b0;
        stub_done   <= 1'b1;
      end
    end else if (tx_start === 1'b1 && stub_en) begin
      stub_active <= 1'b1;
      stub_cnt    <= byte_cyc;
    end
  end
  assign tx_active = stub_en ? stub_active : man_active;
  assign tx_done   = stub_en ? stub_done : man_done;

  // rq drives the requester pins; mq is the scoreboard's copy of what must be sent
  logic [8:0]   rq [N][$];
  logic [8:0]   mq [N][$];
  int           lo_m = N - 1;
  int           cur_m = -1;
  logic         last_m = 1'b0;
  logic [N-1:0] grant_prev = '0;
  logic         rst_neg = 1'b1;

  task automatic push(int r, logic [7:0] b, logic last);
    rq[r].push_back({last, b});
    mq[r].push_back({last, b});
  endtask

  function automatic int rr_next(int lo, logic [N-1:0] v);
    int idx = lo;
    repeat (N) begin
      idx = (idx == N - 1) ? 0 : idx + 1;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic score_cycle();
    logic [8:0] e;
    if (rst_neg) begin
      lo_m = N - 1;
      cur_m = -1;
      grant_prev = '0;
    end else begin
      chk("grant_onehot0", 32'($onehot0(grant)), 1);
      if (grant_prev == '0 && grant != '0) begin
        cur_m = rr_next(lo_m, req_valid);
        chk("rr_owner", 32'(grant), (cur_m < 0) ? 32'h0 : (32'h1 << cur_m));
      end
      if (tx_start === 1'b1) begin
        if (cur_m < 0 || mq[cur_m].size() == 0) begin
          chk("start_without_pending_byte", 1, 0);
        end else begin
          e = mq[cur_m].pop_front();
          chk("sb_tx_data", 32'(tx_data), 32'(e[7:0]));
          chk("sb_req_ready", 32'(req_ready), 32'(grant));
          last_m = e[8];
        end
      end
      if (grant_prev != '0 && grant == '0) begin
        if (timeout_err !== 1'b1) chk("release_only_on_last", 32'(last_m), 1);
        lo_m = cur_m;
        cur_m = -1;
      end
      grant_prev = grant;
    end
    rst_neg = reset;
  endtask

  // Scoreboard first (sees what the DUT sampled), then requesters update pins.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      score_cycle();
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] === 1'b1 && rq[i].size() > 0) void'(rq[i].pop_front());
        req_valid[i] = (rq[i].size() > 0);
        if (rq[i].size() > 0) begin
          req_data[8*i +: 8] = rq[i][0][7:0];
          req_last[i]        = rq[i][0][8];
        end else begin
          req_data[8*i +: 8] = '0;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  task automatic wait_grant(bit want_set, string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (((grant != '0) != want_set) && n < 2000);
    chk(name, 32'((grant != '0) == want_set), 1);
  endtask

  task automatic wait_start(string name, output logic [7:0] d);
    int n = 0;
    do begin @(negedge clk); n++; end while (tx_start !== 1'b1 && n < 2000);
    chk(name, 32'(tx_start === 1'b1), 1);
    d = tx_data;
  endtask

  task automatic wait_done(string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (tx_done !== 1'b1 && n < 2000);
    chk(name, 32'(tx_done === 1'b1), 1);
  endtask

  typedef struct {
    logic [N-1:0] push;
    logic [N-1:0] exp_grant;
    logic [7:0]   exp_byte;
  } rr_vec_t;
  rr_vec_t tbl [11];

  initial begin
    logic [7:0] d;
    int         n;
    int         len;
    int         r;
    logic       bad;
    tbl[0]  = '{3'b001, 3'b001, 8'hA0};
    tbl[1]  = '{3'b111, 3'b010, 8'hA1};
    tbl[2]  = '{3'b000, 3'b100, 8'hA2};
    tbl[3]  = '{3'b000, 3'b001, 8'hA0};
    tbl[4]  = '{3'b100, 3'b100, 8'hA2};
    tbl[5]  = '{3'b111, 3'b001, 8'hA0};
    tbl[6]  = '{3'b000, 3'b010, 8'hA1};
    tbl[7]  = '{3'b001, 3'b100, 8'hA2};
    tbl[8]  = '{3'b000, 3'b001, 8'hA0};
    tbl[9]  = '{3'b011, 3'b010, 8'hA1};
    tbl[10] = '{3'b000, 3'b001, 8'hA0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);

    // Two-byte packet: grant 1 cycle after valid, start 1 cycle later
    @(posedge clk); #1;
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("pkt_grant_lat", 32'(grant), 32'b001);
    chk("pkt_no_early_start", 32'(tx_start), 0);
    chk("pkt_busy", 32'(busy), 1);
    @(negedge clk);
    chk("pkt_start1", 32'(tx_start), 1);
    chk("pkt_data1", 32'(tx_data), 32'h41);
    chk("pkt_ready1", 32'(req_ready), 32'b001);
    wait_done("pkt_done1");
    @(negedge clk);
    chk("pkt_gap_no_start", 32'(tx_start), 0);
    @(negedge clk);
    chk("pkt_start2_lat", 32'(tx_start), 1);
    chk("pkt_data2", 32'(tx_data), 32'h42);
    wait_done("pkt_done2");
    @(negedge clk);
    chk("pkt_grant_clear", 32'(grant), 0);
    chk("pkt_busy_clear", 32'(busy), 0);

    // Round-robin table with single-byte last packets
    for (int v = 0; v < 11; v++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (tbl[v].push[i]) push(i, 8'hA0 + 8'(i), 1'b1);
      wait_grant(1'b1, "rr_grant_seen");
      chk($sformatf("rr_grant_%0d", v), 32'(grant), 32'(tbl[v].exp_grant));
      wait_start("rr_start_seen", d);
      chk($sformatf("rr_byte_%0d", v), 32'(d), 32'(tbl[v].exp_byte));
      wait_grant(1'b0, "rr_release_seen");
    end

    // No preemption: requester 1 mid-packet while requester 2 waits
    @(posedge clk); #1 push(1, 8'h10, 1'b0);
    wait_start("lock_start_10", d);
    chk("lock_byte_10", 32'(d), 32'h10);
    @(posedge clk); #1 push(2, 8'hB0, 1'b1);
    repeat (5) @(posedge clk);
    #1 push(1, 8'h11, 1'b1);
    wait_start("lock_start_11", d);
    chk("lock_byte_11", 32'(d), 32'h11);
    wait_start("lock_start_b0", d);
    chk("lock_byte_b0", 32'(d), 32'hB0);
    wait_grant(1'b0, "lock_release");

    // Watchdog: owner 0 stalls after a non-last byte, requester 1 pending
    @(posedge clk); #1 push(0, 8'h30, 1'b0);
    wait_start("to_start_30", d);
    @(posedge clk); #1 push(1, 8'h31, 1'b1);
    wait_done("to_done_30");
    n = 0;
    do begin @(negedge clk); n++; end while (timeout_err !== 1'b1 && n < 40);
    chk("to_latency", 32'(n), 17);
    chk("to_grant_clear", 32'(grant), 0);
    @(negedge clk);
    chk("to_pulse_single", 32'(timeout_err), 0);
    chk("to_next_grant", 32'(grant), 32'b010);
    wait_start("to_start_31", d);
    chk("to_byte_31", 32'(d), 32'h31);
    wait_grant(1'b0, "to_release");

    // tx_done in the same cycle as tx_start must not advance the block
    @(posedge clk); #1;
    stub_en = 1'b0;
    push(0, 8'h77, 1'b1);
    wait_start("same_start", d);
    man_done = 1'b1;
    man_active = 1'b1;
    @(posedge clk); #1 man_done = 1'b0;
    @(negedge clk);
    chk("same_grant_held", 32'(grant), 32'b001);
    repeat (3) @(negedge clk);
    chk("same_busy_held", 32'(busy), 1);
    @(posedge clk); #1;
    man_done = 1'b1;
    man_active = 1'b0;
    @(posedge clk); #1 man_done = 1'b0;
    @(negedge clk);
    chk("same_later_done_release", 32'(grant), 0);
    @(posedge clk); #1 stub_en = 1'b1;

    // Reset during WAIT_DONE with a long byte still on the line
    byte_cyc = 30;
    @(posedge clk); #1 push(0, 8'h55, 1'b1);
    wait_start("mid_start_55", d);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_tx_start", 32'(tx_start), 0);
    chk("mid_rst_tx_data", 32'(tx_data), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    chk("mid_rst_timeout", 32'(timeout_err), 0);
    @(posedge clk); #1 push(1, 8'h66, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_grant_after_rst", 32'(grant), 32'b010);
    chk("mid_busy_in_load", 32'(busy), 1);
    n = 0;
    bad = 1'b0;
    while (tx_active === 1'b1 && n < 100) begin
      if (tx_start !== 1'b0) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("mid_no_start_while_active", 32'(bad), 0);
    chk("mid_active_dropped", 32'(tx_active), 0);
    chk("mid_stale_done_ignored", 32'(tx_start), 0);
    @(negedge clk);
    chk("mid_start_after_idle", 32'(tx_start), 1);
    chk("mid_byte_66", 32'(tx_data), 32'h66);
    wait_grant(1'b0, "mid_release");

    // Randomized traffic checked by the scoreboard
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      byte_cyc = $urandom_range(1, 6);
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, N - 1);
        if (rq[r].size() < 4) begin
          len = $urandom_range(1, 3);
          for (int j = 0; j < len; j++) push(r, 8'($urandom), j == len - 1);
        end
      end
    end
    n = 0;
    while ((rq[0].size() + rq[1].size() + rq[2].size() != 0 || grant != '0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("rand_drained", 32'(n < 5000), 1);
    for (int i = 0; i < N; i++) chk($sformatf("rand_all_sent_%0d", i), 32'(mq[i].size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end
endmodule
